// File: rtl/exc_ctrl_if.sv
// Bus between the pipeline/CP0 side (master) and the exception sequencer (slave).
// It carries commit flags, interrupt lines, CP0 state and the sequencer's outputs.
interface exc_ctrl_if;
  logic        commit_valid;
  logic [7:0]  commit_exc;
  logic [31:0] commit_pc;
  logic        commit_ds;
  logic [31:0] commit_badaddr;
  logic [5:0]  int_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] count_i;
  logic [31:0] compare_i;
  logic        compare_wr;
  logic [3:0]  exc_type_o;
  logic [31:0] exc_pc_o;
  logic        exc_ds_o;
  logic [31:0] badvaddr_o;
  logic [5:0]  hwi_o;
  logic        flush_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy_o;

  modport master (
    output commit_valid, commit_exc, commit_pc, commit_ds, commit_badaddr, int_i,
           status_i, cause_i, epc_i, count_i, compare_i, compare_wr,
    input  exc_type_o, exc_pc_o, exc_ds_o, badvaddr_o, hwi_o, flush_o,
           redirect_valid, redirect_pc, busy_o
  );

  modport slave (
    input  commit_valid, commit_exc, commit_pc, commit_ds, commit_badaddr, int_i,
           status_i, cause_i, epc_i, count_i, compare_i, compare_wr,
    output exc_type_o, exc_pc_o, exc_ds_o, badvaddr_o, hwi_o, flush_o,
           redirect_valid, redirect_pc, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks one event at commit, pulses its type to CP0,
// flushes the pipeline, then redirects fetch to the handler vector or to EPC.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIR} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [5:0]  sync_reg [SYNC_STAGES];
  logic        timer_int_reg;
  logic [5:0]  hwi_reg;
  logic [3:0]  type_reg;
  logic [31:0] pc_reg, badv_reg, redirect_pc_reg, redirect_pc_next;
  logic        ds_reg;
  logic        int_pend, take, latch_load;
  logic [3:0]  type_sel;
  logic [31:0] badv_sel;
  logic [3:0]  exc_type;
  logic [31:0] exc_pc, badvaddr;
  logic        exc_ds, flush, redirect_valid;
  logic        unused_bits;

  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:10], bus.cause_i[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      timer_int_reg <= 1'b0;
      hwi_reg       <= '0;
    end else begin
      sync_reg[0] <= bus.int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      // A Compare write acknowledges the timer and takes precedence over a new match.
      if (bus.compare_wr)
        timer_int_reg <= 1'b0;
      else if (bus.compare_i != 32'd0 && bus.count_i == bus.compare_i)
        timer_int_reg <= 1'b1;
      hwi_reg <= {timer_int_reg | sync_reg[SYNC_STAGES-1][5], sync_reg[SYNC_STAGES-1][4:0]};
    end
  end

  assign int_pend = bus.status_i[0] & ~bus.status_i[1] &
                    (|({hwi_reg, bus.cause_i[9:8]} & bus.status_i[15:8]));
  assign take     = bus.commit_valid && (int_pend || (|bus.commit_exc));

  // Flag order is {ades,adel,sys,bp,ov,ri,if_adel,eret}.
  always_comb begin
    type_sel = 4'd0;
    badv_sel = 32'd0;
    if (int_pend)                type_sel = 4'd1;
    else if (bus.commit_exc[1])  type_sel = 4'd2;
    else if (bus.commit_exc[2])  type_sel = 4'd4;
    else if (bus.commit_exc[3])  type_sel = 4'd5;
    else if (bus.commit_exc[4])  type_sel = 4'd6;
    else if (bus.commit_exc[5])  type_sel = 4'd7;
    else if (bus.commit_exc[6])  type_sel = 4'd3;
    else if (bus.commit_exc[7])  type_sel = 4'd8;
    else if (bus.commit_exc[0])  type_sel = 4'd9;
    if (type_sel == 4'd2)
      badv_sel = bus.commit_pc;
    else if (type_sel == 4'd3 || type_sel == 4'd8)
      badv_sel = bus.commit_badaddr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      type_reg        <= '0;
      pc_reg          <= '0;
      ds_reg          <= 1'b0;
      badv_reg        <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      redirect_pc_reg <= redirect_pc_next;
      if (latch_load) begin
        type_reg <= type_sel;
        pc_reg   <= bus.commit_pc;
        ds_reg   <= bus.commit_ds;
        badv_reg <= badv_sel;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    redirect_pc_next = redirect_pc_reg;
    latch_load       = 1'b0;
    exc_type         = 4'd0;
    exc_pc           = 32'd0;
    exc_ds           = 1'b0;
    badvaddr         = 32'd0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (take) begin
          latch_load = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        exc_type         = type_reg;
        exc_pc           = pc_reg;
        exc_ds           = ds_reg;
        badvaddr         = badv_reg;
        flush            = 1'b1;
        redirect_pc_next = (type_reg == 4'd9) ? bus.epc_i : EXC_VECTOR;
        if (FLUSH_CYCLES > 1) begin
          cnt_next   = CW'(FLUSH_CYCLES - 1);
          state_next = FLUSH;
        end else begin
          state_next = REDIR;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt_reg <= CW'(1)) state_next = REDIR;
        else                   cnt_next   = cnt_reg - CW'(1);
      end
      REDIR: begin
        redirect_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.exc_type_o     = exc_type;
  assign bus.exc_pc_o       = exc_pc;
  assign bus.exc_ds_o       = exc_ds;
  assign bus.badvaddr_o     = badvaddr;
  assign bus.hwi_o          = hwi_reg;
  assign bus.flush_o        = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.busy_o         = (state_reg != IDLE);
endmodule
